// File: rtl/anim_pattern_bank.sv
// ============================================================================
// Module   : anim_pattern_bank
// Brief    : Run-time writable multi-frame LED pattern store with a playback
//            sequencer; optional LOOP_MODE_EN adds a wrap-around loop input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module anim_pattern_bank #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int FRAMES      = 4,
    parameter int HOLD_CYCLES = 1000,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
`ifdef LOOP_MODE_EN
    input  logic            loop,
`endif
    input  logic [RW-1:0]   indice,
    input  logic            wr_en,
    input  logic [FW-1:0]   wr_frame,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    output logic [COLS-1:0] coluna_sel,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [FW-1:0]   frame_ptr, frame_nx;
    logic [HW-1:0]   hold_cnt, hold_nx;
    logic [COLS-1:0] mem [FRAMES][ROWS];

    logic rd_ok, wr_row_ok, wr_frame_ok;
    logic last_hold, last_frame, wrap;

    // Range checks collapse to constants when the index width exactly fits.
    generate
        if ((1 << RW) == ROWS) begin : g_row_full
            assign rd_ok     = 1'b1;
            assign wr_row_ok = 1'b1;
        end else begin : g_row_chk
            assign rd_ok     = (indice < RW'(ROWS));
            assign wr_row_ok = (wr_row < RW'(ROWS));
        end
        if ((1 << FW) == FRAMES) begin : g_frame_full
            assign wr_frame_ok = 1'b1;
        end else begin : g_frame_chk
            assign wr_frame_ok = (wr_frame < FW'(FRAMES));
        end
    endgenerate

`ifdef LOOP_MODE_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    assign last_hold  = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign last_frame = (frame_ptr == FW'(FRAMES - 1));

    always_comb begin
        state_nx = state;
        frame_nx = frame_ptr;
        hold_nx  = hold_cnt;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = PLAY;
                    frame_nx = '0;
                    hold_nx  = '0;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_nx = IDLE;
                    frame_nx = '0;
                    hold_nx  = '0;
                end else if (last_hold) begin
                    hold_nx = '0;
                    if (!last_frame) begin
                        frame_nx = frame_ptr + FW'(1);
                    end else if (wrap) begin
                        frame_nx = '0;
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    hold_nx = hold_cnt + HW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
                frame_nx = '0;
                hold_nx  = '0;
            end
            default: begin
                state_nx = IDLE;
                frame_nx = '0;
                hold_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame_ptr  <= '0;
            hold_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            coluna_sel <= '0;
        end else begin
            state      <= state_nx;
            frame_ptr  <= frame_nx;
            hold_cnt   <= hold_nx;
            busy       <= (state_nx == PLAY);
            done       <= (state_nx == DONE);
            coluna_sel <= (state == PLAY && rd_ok) ? mem[frame_ptr][indice] : '0;
        end
    end

    // Reset image is a growing bar: frame f lights rows 0..f.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int f = 0; f < FRAMES; f++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem[f][r] <= (r <= f) ? '1 : '0;
                end
            end
        end else if (wr_en && wr_frame_ok && wr_row_ok) begin
            mem[wr_frame][wr_row] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_anim_pattern_bank.sv
// ============================================================================
// Module   : tb_anim_pattern_bank
// Brief    : Vector-table and scoreboard bench for anim_pattern_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anim_pattern_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Main instance: 8x8, 4 frames, hold 4
    logic       s1 = 0, a1 = 0, we1 = 0;
    logic [2:0] ind1 = 0, wr1r = 0;
    logic [1:0] wf1 = 0;
    logic [7:0] wd1 = 0, col1;
    logic       busy1, done1;
    // Second instance: 4 cols, 6 rows, 3 frames, hold 1 (non-power-of-two ranges)
    logic       s2 = 0, a2 = 0, we2 = 0;
    logic [2:0] ind2 = 0, wr2r = 0;
    logic [1:0] wf2 = 0;
    logic [3:0] wd2 = 0, col2;
    logic       busy2, done2;
`ifdef LOOP_MODE_EN
    logic       loop_in = 0;
`endif

    anim_pattern_bank #(.COLS(8), .ROWS(8), .FRAMES(4), .HOLD_CYCLES(4)) dut1 (
        .clock(clk), .reset(rst), .start(s1), .abort(a1),
`ifdef LOOP_MODE_EN
        .loop(loop_in),
`endif
        .indice(ind1), .wr_en(we1), .wr_frame(wf1), .wr_row(wr1r), .wr_data(wd1),
        .coluna_sel(col1), .busy(busy1), .done(done1));

    anim_pattern_bank #(.COLS(4), .ROWS(6), .FRAMES(3), .HOLD_CYCLES(1)) dut2 (
        .clock(clk), .reset(rst), .start(s2), .abort(a2),
`ifdef LOOP_MODE_EN
        .loop(1'b0),
`endif
        .indice(ind2), .wr_en(we2), .wr_frame(wf2), .wr_row(wr2r), .wr_data(wd2),
        .coluna_sel(col2), .busy(busy2), .done(done2));

    typedef struct {
        int         which;
        logic       start, abort;
        logic [2:0] indice;
        logic       wr_en;
        logic [1:0] wr_frame;
        logic [2:0] wr_row;
        logic [7:0] wr_data;
        logic       chk_col;
        logic [7:0] e_col;
        logic       e_busy, e_done;
    } vec_t;

    vec_t       tbl[$];
    vec_t       sb[$];
    logic [7:0] m1 [4][8];
    logic [7:0] m2 [3][6];
    int         n_chk = 0, n_pass = 0, step_no = 0;
    string      phase = "init";

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
    endtask

    function automatic void mem_default();
        for (int f = 0; f < 4; f++)
            for (int r = 0; r < 8; r++) m1[f][r] = (r <= f) ? 8'hFF : 8'h00;
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < 6; r++) m2[f][r] = (r <= f) ? 8'h0F : 8'h00;
    endfunction

    function automatic logic [7:0] rd(input int w, input int f, input int r);
        if (w == 0) return m1[f][r];
        if (r >= 6) return 8'h00;
        return m2[f][r];
    endfunction

    function automatic void wr(input int w, input int f, input int r, input logic [7:0] d);
        if (w == 0) m1[f][r] = d;
        else if (f < 3 && r < 6) m2[f][r] = {4'h0, d[3:0]};
    endfunction

    function automatic vec_t idle(input int w);
        vec_t v;
        v.which = w; v.start = 0; v.abort = 0; v.indice = 0; v.wr_en = 0;
        v.wr_frame = 0; v.wr_row = 0; v.wr_data = 0; v.chk_col = 1;
        v.e_col = 0; v.e_busy = 0; v.e_done = 0;
        return v;
    endfunction

    // One playback: step 0 issues start, steps 1..total are PLAY cycles,
    // step total+1 is the DONE cycle. ind_const<0 sweeps indice 0..7.
    task automatic build_play(input int w, input int ind_const, input logic start_all,
                              input int wr_step, input logic [2:0] wr_r, input logic [7:0] wr_d);
        int   hold, total;
        vec_t v;
        hold  = (w == 0) ? 4 : 1;
        total = ((w == 0) ? 4 : 3) * hold;
        for (int j = 0; j <= total + 1; j++) begin
            v = idle(w);
            v.start  = (j == 0) || start_all;
            v.indice = (ind_const < 0) ? 3'(j % 8) : 3'(ind_const);
            if (j >= 1 && j <= total) v.e_col = rd(w, (j - 1) / hold, int'(v.indice));
            v.e_busy = (j < total);
            v.e_done = (j == total);
            if (j == wr_step) begin
                v.wr_en = 1; v.wr_frame = 2'((j - 1) / hold); v.wr_row = wr_r; v.wr_data = wr_d;
                wr(w, (j - 1) / hold, int'(wr_r), wr_d);
            end
            tbl.push_back(v);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t       e;
        logic [7:0] ac;
        logic       ab, ad;
        if (v.which == 0) begin
            s1 = v.start; a1 = v.abort; ind1 = v.indice; we1 = v.wr_en;
            wf1 = v.wr_frame; wr1r = v.wr_row; wd1 = v.wr_data;
        end else begin
            s2 = v.start; a2 = v.abort; ind2 = v.indice; we2 = v.wr_en;
            wf2 = v.wr_frame; wr2r = v.wr_row; wd2 = v.wr_data[3:0];
        end
        sb.push_back(v);
        @(posedge clk); #1;
        step_no++;
        e = sb.pop_front();
        if (e.which == 0) begin ac = col1; ab = busy1; ad = done1; end
        else begin ac = {4'h0, col2}; ab = busy2; ad = done2; end
        if (e.chk_col) check({phase, ".col"}, int'(ac), int'(e.e_col));
        check({phase, ".busy"}, int'(ab), int'(e.e_busy));
        check({phase, ".done"}, int'(ad), int'(e.e_done));
    endtask

    task automatic run_tbl(input string name);
        phase = name;
        while (tbl.size() > 0) apply(tbl.pop_front());
        s1 = 0; a1 = 0; we1 = 0; s2 = 0; a2 = 0; we2 = 0;
    endtask

    initial begin
        vec_t v;
        mem_default();
        rst = 1;
        #1;
        phase = "reset";
        check("reset.col", int'(col1), 0);
        check("reset.busy", int'(busy1), 0);
        check("reset.done", int'(done1), 0);
        @(posedge clk); #1;
        rst = 0;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) tbl.push_back(idle(0));
        run_tbl("idle");

        // 2: full sweep playback with default image
        build_play(0, -1, 0, -1, 0, 0);
        tbl.push_back(idle(0));
        run_tbl("play_sweep");

        // 3: user write then replay on that row
        v = idle(0); v.wr_en = 1; v.wr_frame = 2; v.wr_row = 5; v.wr_data = 8'hA5;
        tbl.push_back(v); wr(0, 2, 5, 8'hA5);
        build_play(0, 5, 0, -1, 0, 0);
        run_tbl("play_written");

        // 4: abort at frame 1, third hold cycle; start ignored while abort
        build_play(0, -1, 0, -1, 0, 0);
        while (tbl.size() > 8) void'(tbl.pop_back());
        v = tbl.pop_back();
        v.abort = 1; v.e_busy = 0; v.chk_col = 0;
        tbl.push_back(v);
        for (int i = 0; i < 4; i++) begin
            v = idle(0);
            v.start = (i == 1); v.abort = (i == 1);
            tbl.push_back(v);
        end
        run_tbl("abort");
        build_play(0, -1, 0, -1, 0, 0);
        run_tbl("replay");

        // 5: start held through playback; write to the displayed row
        build_play(0, 2, 1, 2, 3'd2, 8'h3C);
        tbl.push_back(idle(0));
        tbl.push_back(idle(0));
        run_tbl("start_held");

`ifdef LOOP_MODE_EN
        // 6: loop wraps once, dropped during the second pass through frame 2
        phase = "loop";
        for (int j = 0; j <= 33; j++) begin
            v = idle(0);
            v.start  = (j == 0);
            v.indice = 3'(j % 8);
            if (j >= 1 && j <= 32) v.e_col = rd(0, ((j - 1) / 4) % 4, j % 8);
            v.e_busy = (j < 32);
            v.e_done = (j == 32);
            loop_in  = (j <= 26);
            apply(v);
        end
        loop_in = 0; s1 = 0;
`endif

        // Second instance: out-of-range writes dropped, in-range write lands
        mem_default();
        v = idle(1); v.wr_en = 1; v.wr_frame = 3; v.wr_row = 0; v.wr_data = 8'h0A; tbl.push_back(v);
        v = idle(1); v.wr_en = 1; v.wr_frame = 0; v.wr_row = 6; v.wr_data = 8'h05; tbl.push_back(v);
        v = idle(1); v.wr_en = 1; v.wr_frame = 1; v.wr_row = 4; v.wr_data = 8'h09; tbl.push_back(v);
        wr(1, 1, 4, 8'h09);
        for (int r = 0; r < 8; r++) build_play(1, r, 0, -1, 0, 0);
        run_tbl("small_bank");

        // Reset mid-playback discards user writes
        build_play(0, 0, 0, -1, 0, 0);
        while (tbl.size() > 6) void'(tbl.pop_back());
        run_tbl("pre_reset");
        #2 rst = 1;
        #1;
        phase = "mid_reset";
        check("mid_reset.busy", int'(busy1), 0);
        check("mid_reset.col", int'(col1), 0);
        @(posedge clk); #1;
        rst = 0;
        mem_default();
        build_play(0, 5, 0, -1, 0, 0);
        build_play(0, 2, 0, -1, 0, 0);
        run_tbl("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
